// File: rtl/reg_file_2r1w_sweep.sv
// WIDTH x DEPTH register file: one write port, two registered read ports,
// write-first bypass, per-entry valid flags and a sequenced sweep clear.
//
// Ports:
//   CLK, CLRN         clock, async active-low reset
//   WR, WA, WD        write enable / address / data
//   RA0, RA1          read addresses
//   RD0, RD1          registered read data
//   RV0, RV1          registered valid flag of the entry read
//   CLR_REQ           sweep clear request (level)
//   BUSY, DONE        sweep in progress / one-cycle completion pulse
//   WR_ERR            one-cycle pulse: previous write rejected
module reg_file_2r1w_sweep #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             WR,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [AW-1:0]    RA0,
  input  logic [AW-1:0]    RA1,
  output logic [WIDTH-1:0] RD0,
  output logic [WIDTH-1:0] RD1,
  output logic             RV0,
  output logic             RV1,
  input  logic             CLR_REQ,
  output logic             BUSY,
  output logic             DONE,
  output logic             WR_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_FINISH
  } state_t;

  localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] L_LAST  = AW'(DEPTH-1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_ptr;
  logic             r_busy;
  logic             r_done;
  logic             r_wr_err;

  logic                  w_wa_ok;
  logic                  w_wr_ok;
  logic [1:0][AW-1:0]    w_ra;
  logic [1:0][WIDTH-1:0] w_rd_nxt;
  logic [1:0]            w_rv_nxt;
  logic [1:0][WIDTH-1:0] r_rd;
  logic [1:0]            r_rv;

  assign w_wa_ok = ({1'b0, WA} < L_DEPTH);
  // A request seen in IDLE wins over a same-edge write.
  assign w_wr_ok = WR & w_wa_ok &
                   (r_state == S_IDLE) & ~CLR_REQ;
  assign w_ra    = {RA1, RA0};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (CLR_REQ) w_state_nxt = S_SWEEP;
      end
      S_SWEEP: begin
        if (r_ptr == L_LAST) w_state_nxt = S_FINISH;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= (w_state_nxt == S_SWEEP);
      r_done   <= (w_state_nxt == S_FINISH);
      r_wr_err <= WR & ~w_wr_ok;
      if (r_state == S_SWEEP) r_ptr <= r_ptr + AW'(1);
      else                    r_ptr <= '0;
    end
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid <= '0;
    end else if (w_wr_ok) begin
      r_mem[WA]   <= WD;
      r_valid[WA] <= 1'b1;
    end else if (r_state == S_SWEEP) begin
      r_mem[r_ptr]   <= '0;
      r_valid[r_ptr] <= 1'b0;
    end
  end

  // Out-of-range addresses read as empty; an accepted write
  // to the same address is forwarded (write-first).
  always_comb begin
    w_rd_nxt = '0;
    w_rv_nxt = '0;
    for (int p = 0; p < 2; p++) begin
      if ({1'b0, w_ra[p]} < L_DEPTH) begin
        if (w_wr_ok && (WA == w_ra[p])) begin
          w_rd_nxt[p] = WD;
          w_rv_nxt[p] = 1'b1;
        end else begin
          w_rd_nxt[p] = r_mem[w_ra[p]];
          w_rv_nxt[p] = r_valid[w_ra[p]];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_rd <= '0;
      r_rv <= '0;
    end else begin
      r_rd <= w_rd_nxt;
      r_rv <= w_rv_nxt;
    end
  end

  assign RD0    = r_rd[0];
  assign RD1    = r_rd[1];
  assign RV0    = r_rv[0];
  assign RV1    = r_rv[1];
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign WR_ERR = r_wr_err;

endmodule

// File: tb/tb_reg_file_2r1w_sweep.sv
// Directed bench for reg_file_2r1w_sweep
// (default 16-entry instance plus a 12-entry instance).
module tb_reg_file_2r1w_sweep;

  logic       CLK = 1'b0;
  logic       CLRN = 1'b0;
  logic       WR = 1'b0;
  logic [3:0] WA = '0;
  logic [3:0] WD = '0;
  logic [3:0] RA0 = '0;
  logic [3:0] RA1 = '0;
  logic [3:0] RD0, RD1;
  logic       RV0, RV1;
  logic       CLR_REQ = 1'b0;
  logic       BUSY, DONE, WR_ERR;

  logic       WR12 = 1'b0;
  logic [3:0] WA12 = '0;
  logic [3:0] WD12 = '0;
  logic [3:0] RA0_12 = '0;
  logic [3:0] RA1_12 = '0;
  logic [3:0] RD0_12, RD1_12;
  logic       RV0_12, RV1_12;
  logic       BUSY12, DONE12, WR_ERR12;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  reg_file_2r1w_sweep u_dut (
    .CLK(CLK), .CLRN(CLRN),
    .WR(WR), .WA(WA), .WD(WD),
    .RA0(RA0), .RA1(RA1),
    .RD0(RD0), .RD1(RD1),
    .RV0(RV0), .RV1(RV1),
    .CLR_REQ(CLR_REQ),
    .BUSY(BUSY), .DONE(DONE),
    .WR_ERR(WR_ERR)
  );

  reg_file_2r1w_sweep #(
    .WIDTH(4), .DEPTH(12), .AW(4)
  ) u_dut12 (
    .CLK(CLK), .CLRN(CLRN),
    .WR(WR12), .WA(WA12), .WD(WD12),
    .RA0(RA0_12), .RA1(RA1_12),
    .RD0(RD0_12), .RD1(RD1_12),
    .RV0(RV0_12), .RV1(RV1_12),
    .CLR_REQ(1'b0),
    .BUSY(BUSY12), .DONE(DONE12),
    .WR_ERR(WR_ERR12)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int busy_n;
    int done_n;
    int done_at;

    #2;
    chk("rst_rd0", 32'(RD0), 0);
    chk("rst_rv0", 32'(RV0), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_wrerr", 32'(WR_ERR), 0);
    #10;
    CLRN = 1'b1;

    // read after reset
    RA0 = 4'd3; RA1 = 4'd15;
    tick();
    chk("rd_rst_rd0", 32'(RD0), 0);
    chk("rd_rst_rv0", 32'(RV0), 0);
    chk("rd_rst_rd1", 32'(RD1), 0);
    chk("rd_rst_rv1", 32'(RV1), 0);
    chk("rd_rst_busy", 32'(BUSY), 0);

    // write then read on both ports
    WR = 1'b1; WA = 4'd5; WD = 4'hA;
    tick();
    WR = 1'b0;
    RA0 = 4'd5; RA1 = 4'd5;
    tick();
    chk("wr5_rd0", 32'(RD0), 32'hA);
    chk("wr5_rv0", 32'(RV0), 1);
    chk("wr5_rd1", 32'(RD1), 32'hA);
    chk("wr5_rv1", 32'(RV1), 1);

    // bypass on port 0, unwritten entry on port 1
    WR = 1'b1; WA = 4'd7; WD = 4'h3;
    RA0 = 4'd7; RA1 = 4'd6;
    tick();
    WR = 1'b0;
    chk("byp_rd0", 32'(RD0), 32'h3);
    chk("byp_rv0", 32'(RV0), 1);
    chk("byp_rd1", 32'(RD1), 0);
    chk("byp_rv1", 32'(RV1), 0);
    chk("byp_wrerr", 32'(WR_ERR), 0);

    // fill with value = address
    for (int a = 0; a < 16; a++) begin
      WR = 1'b1; WA = 4'(a); WD = 4'(a);
      tick();
    end
    WR = 1'b0;

    // sweep with a write colliding on the start edge
    CLR_REQ = 1'b1;
    WR = 1'b1; WA = 4'd2; WD = 4'hF;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (BUSY === 1'b1) busy_n++;
      if (DONE === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k == 0) begin
        chk("sw_start_wrerr", 32'(WR_ERR), 1);
        CLR_REQ = 1'b0;
        WA = 4'd9;
        RA0 = 4'd2;
      end
      if (k == 1) begin
        chk("sw_busy_wrerr", 32'(WR_ERR), 1);
        chk("sw_rej_rd0", 32'(RD0), 32'h2);
        chk("sw_rej_rv0", 32'(RV0), 1);
        WR = 1'b0;
      end
      if (k == 2)
        chk("sw_wrerr_clr", 32'(WR_ERR), 0);
      if (k == 4) begin
        RA0 = 4'd2; RA1 = 4'd9;
      end
      if (k == 5) begin
        chk("mid_rd0", 32'(RD0), 0);
        chk("mid_rv0", 32'(RV0), 0);
        chk("mid_rd1", 32'(RD1), 32'h9);
        chk("mid_rv1", 32'(RV1), 1);
      end
    end
    chk("sw_busy_cycles", 32'(busy_n), 16);
    chk("sw_done_pulses", 32'(done_n), 1);
    chk("sw_done_at", 32'(done_at), 16);

    // everything wiped
    for (int a = 0; a < 16; a++) begin
      RA0 = 4'(a); RA1 = 4'(15 - a);
      tick();
      chk("clr_rd0", 32'(RD0), 0);
      chk("clr_rv0", 32'(RV0), 0);
      chk("clr_rd1", 32'(RD1), 0);
      chk("clr_rv1", 32'(RV1), 0);
    end

    // 12-entry instance: out-of-range write and read
    WR12 = 1'b1; WA12 = 4'd13; WD12 = 4'h5;
    RA0_12 = 4'd13; RA1_12 = 4'd11;
    tick();
    chk("d12_wrerr", 32'(WR_ERR12), 1);
    chk("d12_rd0", 32'(RD0_12), 0);
    chk("d12_rv0", 32'(RV0_12), 0);
    chk("d12_rd1", 32'(RD1_12), 0);
    chk("d12_rv1", 32'(RV1_12), 0);
    WA12 = 4'd11; WD12 = 4'h7;
    tick();
    WR12 = 1'b0;
    chk("d12_ok_wrerr", 32'(WR_ERR12), 0);
    chk("d12_last_rd1", 32'(RD1_12), 32'h7);
    chk("d12_last_rv1", 32'(RV1_12), 1);

    // reset in the middle of a sweep
    WR = 1'b1; WA = 4'd14; WD = 4'hC;
    tick();
    WR = 1'b0;
    CLR_REQ = 1'b1;
    RA0 = 4'd14;
    tick();
    CLR_REQ = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("pre_rst_busy", 32'(BUSY), 1);
    chk("pre_rst_rd0", 32'(RD0), 32'hC);
    chk("pre_rst_rv0", 32'(RV0), 1);
    #1;
    CLRN = 1'b0;
    #1;
    chk("arst_rd0", 32'(RD0), 0);
    chk("arst_rv0", 32'(RV0), 0);
    chk("arst_busy", 32'(BUSY), 0);
    chk("arst_done", 32'(DONE), 0);
    chk("arst_rd1_12", 32'(RD1_12), 0);
    #20;
    @(negedge CLK);
    CLRN = 1'b1;
    done_n = 0;
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (DONE === 1'b1) done_n++;
      if (BUSY === 1'b1) busy_n++;
    end
    chk("arst_no_done", 32'(done_n), 0);
    chk("arst_no_busy", 32'(busy_n), 0);
    chk("arst_e14_rd0", 32'(RD0), 0);
    chk("arst_e14_rv0", 32'(RV0), 0);

    WR = 1'b1; WA = 4'd1; WD = 4'h6;
    tick();
    WR = 1'b0;
    chk("post_wrerr", 32'(WR_ERR), 0);
    RA0 = 4'd1;
    tick();
    chk("post_rd0", 32'(RD0), 32'h6);
    chk("post_rv0", 32'(RV0), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
